// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types, reset PC and branch/jump target helpers for instruction fetch
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // STALE means a request is still on the bus but its data belongs to a discarded path
  typedef enum logic {
    FETCH = 1'b0,
    STALE = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  // Conditional branch: word offset relative to the instruction after the branch
  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
    logic [31:0] offset;
    offset = {{14{imm[15]}}, imm, 2'b00};
    return pc + 32'd4 + offset;
  endfunction

  // J-type: keep the 256 MB region of the next sequential PC
  function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [25:0] addr);
    return ((pc + 32'd4) & 32'hF000_0000) | {4'b0000, addr, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction memory, decoder and redirect signals of the fetch stage
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_addr;
  logic        jr;
  logic [31:0] jr_target;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, stall, branch_taken, branch_imm,
           jump, jump_addr, jr, jr_target
  );

  // Memory and decode/execute side
  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ack, imem_rdata, stall, branch_taken, branch_imm,
           jump, jump_addr, jr, jr_target
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small in-order instruction queue with flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  fetch_entry_t             i_entry,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output fetch_entry_t             o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  // Never pop an empty queue even if the caller asks
  assign w_pop   = i_pop && (r_count != '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Pointer, count and storage update; flush empties without touching storage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, imem req/ack handshake, redirect handling and instruction queue
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  fetch_if.master bus
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  fetch_state_t  r_state;
  fetch_state_t  w_state_next;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_next;
  logic          r_req;
  logic          w_req_next;
  logic [31:0]   r_addr;
  logic [31:0]   w_addr_next;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_next;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic          w_valid;
  logic          w_take;
  logic          w_redirect;
  logic          w_acked;
  logic          w_push;
  logic          w_pending;
  logic [31:0]   w_target;

  assign w_valid    = (w_count != '0);
  assign w_take     = w_valid && !bus.stall;
  assign w_redirect = w_take && (bus.jr || bus.jump || bus.branch_taken);
  assign w_acked    = r_req && bus.imem_ack;
  // A request still waiting for ack after this edge must keep req/addr stable
  assign w_pending  = r_req && !bus.imem_ack;
  // Data acked alongside a redirect, or while STALE, is from the wrong path
  assign w_push     = w_acked && (r_state == FETCH) && !w_redirect;
  assign w_push_entry = '{pc: r_fetch_pc, word: bus.imem_rdata};

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (w_take),
    .i_flush (w_redirect),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.instr       = w_head.word;
  assign bus.instr_pc    = w_head.pc;
  assign bus.instr_valid = w_valid;

  // Redirect target with jr > jump > branch priority
  always_comb begin
    w_target = branch_target(w_head.pc, bus.branch_imm);
    if (bus.jr)
      w_target = bus.jr_target & 32'hFFFF_FFFC;
    else if (bus.jump)
      w_target = jump_target(w_head.pc, bus.jump_addr);
  end

  // Queue occupancy after this edge, used by the issue rule
  always_comb begin
    w_count_next = w_count;
    if (w_redirect)
      w_count_next = '0;
    else begin
      case ({w_push, w_take})
        2'b10:   w_count_next = w_count + CNT_ONE;
        2'b01:   w_count_next = w_count - CNT_ONE;
        default: w_count_next = w_count;
      endcase
    end
  end

  // Next state, fetch PC and request issue
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_req_next      = r_req;
    w_addr_next     = r_addr;
    case (r_state)
      FETCH: begin
        if (w_redirect) begin
          w_fetch_pc_next = w_target;
          if (w_pending) w_state_next = STALE;
        end else if (w_push) begin
          w_fetch_pc_next = r_fetch_pc + 32'd4;
        end
      end
      STALE: begin
        if (w_redirect) w_fetch_pc_next = w_target;
        if (w_acked) w_state_next = FETCH;
      end
      default: w_state_next = FETCH;
    endcase
    if (!w_pending) begin
      if ((w_state_next == FETCH) && (w_count_next < DEPTH_C)) begin
        w_req_next  = 1'b1;
        w_addr_next = w_fetch_pc_next;
      end else begin
        w_req_next  = 1'b0;
      end
    end
  end

  // State, PC and bus registers; reset abandons any in-flight request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= FETCH;
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_req      <= w_req_next;
      r_addr     <= w_addr_next;
    end
  end

endmodule
